// File: rtl/periph_arbiter.sv
// Two-requester arbiter for the 16-bit peripheral send/ack port: round-robin on ties,
// four-phase handshake with per-phase timeout, done/error code returned to the winner.
module periph_arbiter #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        send0,
    input  logic [DATA_W-1:0] dado0,
    output logic [1:0]        ack0,
    input  logic [1:0]        send1,
    input  logic [DATA_W-1:0] dado1,
    output logic [1:0]        ack1,
    output logic [DATA_W-1:0] p_dado,
    output logic [1:0]        p_send,
    input  logic [1:0]        p_ack,
    output logic [1:0]        grant,
    output logic              err,
    output logic [CNT_W-1:0]  xfer_count
);

    // state | meaning
    // IDLE  | no owner, arbitrate on any request
    // P_REQ | p_send asserted, waiting for p_ack = 01
    // P_REL | p_send released, waiting for p_ack = 00
    // R_ACK | done code to owner, waiting for owner to drop send
    // ERR   | error code to owner, waiting for owner to drop send
    typedef enum logic [2:0] {IDLE, P_REQ, P_REL, R_ACK, ERR} state_t;

    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t          state;
    logic            owner;
    logic            last;
    logic [TO_W-1:0] to_cnt;

    logic req0;
    logic req1;
    logic pick;
    logic owner_req;
    logic to_hit;

    assign req0      = |send0;
    assign req1      = |send1;
    // On a tie the requester that did not own the previous transfer wins.
    assign pick      = (req0 && req1) ? ~last : req1;
    assign owner_req = owner ? req1 : req0;
    assign to_hit    = (to_cnt == TO_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last       <= 1'b1;
            to_cnt     <= '0;
            p_dado     <= '0;
            p_send     <= 2'b00;
            ack0       <= 2'b00;
            ack1       <= 2'b00;
            grant      <= 2'b00;
            err        <= 1'b0;
            xfer_count <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner  <= pick;
                        p_dado <= pick ? dado1 : dado0;
                        grant  <= pick ? 2'b10 : 2'b01;
                        p_send <= 2'b01;
                        to_cnt <= '0;
                        state  <= P_REQ;
                    end
                end
                P_REQ: begin
                    if (p_ack == 2'b01) begin
                        p_send <= 2'b00;
                        to_cnt <= '0;
                        state  <= P_REL;
                    end else if (to_hit) begin
                        p_send <= 2'b00;
                        err    <= 1'b1;
                        ack0   <= owner ? 2'b00 : 2'b10;
                        ack1   <= owner ? 2'b10 : 2'b00;
                        state  <= ERR;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                P_REL: begin
                    if (p_ack == 2'b00) begin
                        xfer_count <= xfer_count + 1'b1;
                        last       <= owner;
                        ack0       <= owner ? 2'b00 : 2'b01;
                        ack1       <= owner ? 2'b01 : 2'b00;
                        state      <= R_ACK;
                    end else if (to_hit) begin
                        err   <= 1'b1;
                        ack0  <= owner ? 2'b00 : 2'b10;
                        ack1  <= owner ? 2'b10 : 2'b00;
                        state <= ERR;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                R_ACK: begin
                    if (!owner_req) begin
                        ack0  <= 2'b00;
                        ack1  <= 2'b00;
                        grant <= 2'b00;
                        state <= IDLE;
                    end
                end
                ERR: begin
                    if (!owner_req) begin
                        last  <= owner;
                        ack0  <= 2'b00;
                        ack1  <= 2'b00;
                        grant <= 2'b00;
                        state <= IDLE;
                    end
                end
                default: begin
                    p_send <= 2'b00;
                    ack0   <= 2'b00;
                    ack1   <= 2'b00;
                    grant  <= 2'b00;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
